rom_reader: RTL
===============

Name: rom_reader

Overview:
- Burst read sequencer that sits directly upstream of rom_top.
- Drives rom_top's address input and takes rom_top's q output back in.
- On a start command it reads a programmable-length run of consecutive ROM words.
- It delivers the words downstream as a valid/ready stream, absorbing ROM read latency and downstream stalls with a small internal FIFO.

Parameters:
- ADDR_W, 8, ROM address width (matches rom_top iwv_addr).
- DATA_W, 8, ROM data width (matches rom_top owv_q).
- ROM_LAT, 2, clock cycles from address presented to q valid; legal range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; power of two; must be >= ROM_LAT+1.

Ports:
- iws_clk  in  1  system clock, 50 MHz; all logic on its rising edge.
- iws_rst  in  1  synchronous, active-high reset.
- iws_start  in  1  one-cycle start pulse; sampled only in IDLE.
- iwv_base_addr  in  ADDR_W  first ROM address of the burst, captured on accepted start.
- iwv_len  in  ADDR_W+1  burst length in words, 0..256, captured on accepted start.
- owv_rom_addr  out  ADDR_W  address to rom_top iwv_addr.
- iwv_rom_q  in  DATA_W  data from rom_top owv_q.
- owv_data  out  DATA_W  stream data (FIFO head).
- ows_valid  out  1  owv_data valid.
- iws_ready  in  1  downstream accepts; a beat transfers when ows_valid && iws_ready.
- ows_busy  out  1  burst in progress.
- ows_done  out  1  one-cycle pulse at burst completion.
- owv_checksum  out  16  burst checksum (see Optional Feature).

Behaviour:
- Reset values: owv_rom_addr=0, ows_valid=0, ows_busy=0, ows_done=0, owv_checksum=0, owv_data=0; FIFO empty, in-flight pipe cleared, FSM=IDLE. Reset in any state aborts the burst immediately; no done pulse is generated.
- FSM IDLE -> RUN:
  - In IDLE with iws_start=1 and iwv_len!=0: capture base/len, set ows_busy=1 next cycle, go to RUN.
  - iws_start with iwv_len=0: ows_done pulses next cycle, no beats, stays in IDLE.
- RUN, issue rule:
  - An address is issued in a cycle when issued_count < len AND (inflight + fifo_count) < FIFO_DEPTH.
  - owv_rom_addr = base + issued_count (mod 2^ADDR_W); wraps 8'hFF->8'h00.
  - When not issuing, owv_rom_addr holds its last value.
- In-flight tracking:
  - A ROM_LAT-deep shift register of issue flags. When a flag exits it, iwv_rom_q is written into the FIFO that cycle.
  - The credit rule guarantees the FIFO never overflows.
- RUN -> DRAIN: when issued_count reaches len.
- DRAIN -> DONE: when the in-flight pipe and FIFO are empty and delivered_count == len.
- DONE: ows_done=1 and ows_busy=0 for exactly one cycle, then -> IDLE.
- iws_start outside IDLE is ignored.
- Stream rules:
  - ows_valid = FIFO non-empty; owv_data = FIFO head.
  - Data is held stable while ows_valid && !iws_ready.
  - Simultaneous FIFO write and read is legal and leaves the count unchanged.
- Latency: the first beat can be valid at cycle start+1+ROM_LAT+1. With iws_ready held at 1, throughput is one beat per cycle.
- Counters are ADDR_W+1 bits so len=256 is representable.

Optional Feature:
- Macro: ROM_READER_CHECKSUM_EN.
- Defined:
  - owv_checksum is a 16-bit wrapping sum of all beats transferred in the current burst.
  - It clears on accepted start and is stable and valid from the ows_done cycle until the next accepted start.
- Undefined: owv_checksum is tied to 16'h0000 and no accumulator is built.

Decomposition:
- Shared include rom_defs.vh holds:
  - ROM address/data width defines (shared with rom_top);
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3;
  - the checksum width.
- One sub-module: rom_reader_fifo, a synchronous FIFO (parameters DATA_W, FIFO_DEPTH) with wr_en/rd_en/empty/full/count and a first-word-fall-through head output.

Test Plan:
Bench ROM model: q = addr ^ 8'hA5, delayed ROM_LAT cycles.
- base=8'h10, len=16, iws_ready=1 -> 16 consecutive beats 8'hB5..8'hBA… (addr^A5 for 10..1F), one per cycle, then a single ows_done; with macro, checksum = sum of those 16 values.
- base=8'hFC, len=8 -> addresses FC,FD,FE,FF,00,01,02,03 issued; data matches wrapped addresses.
- len=20, iws_ready toggled 1/0 every 3 cycles -> no lost/duplicated beats, owv_data stable during stalls, inflight+fifo_count never exceeds 4.
- iws_start during RUN with different base -> ignored; original burst completes unchanged.
- len=0 -> ows_done pulse at start+1, ows_valid never asserted; len=256 base=0 -> 256 beats, done once.
- iws_rst asserted mid-burst at beat 5 -> next cycle all outputs at reset values, no done pulse; a new start then runs correctly from scratch.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// Shared ROM reader definitions: widths, FSM state encoding and an in-flight flag counter.
// The checksum width is used only when ROM_READER_CHECKSUM_EN is defined.
package rom_reader_pkg;

  localparam int unsigned RomAddrW  = 8;
  localparam int unsigned RomDataW  = 8;
  localparam int unsigned ChecksumW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // The in-flight pipe is padded to 4 stages, the largest legal ROM latency.
  function automatic logic [2:0] count_flags(input logic [3:0] flags);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, flags[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
// The head reads as zero while the FIFO is empty.
module rom_reader_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign count = count_q;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && !full;
  assign head  = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rom_reader.sv
// Burst ROM read sequencer feeding a valid/ready stream through a small credit-limited FIFO.
// Optional burst checksum is built only when ROM_READER_CHECKSUM_EN is defined.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = RomAddrW,
  parameter int unsigned DATA_W     = RomDataW,
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 iws_clk,
  input  logic                 iws_rst,
  input  logic                 iws_start,
  input  logic [ADDR_W-1:0]    iwv_base_addr,
  input  logic [ADDR_W:0]      iwv_len,
  output logic [ADDR_W-1:0]    owv_rom_addr,
  input  logic [DATA_W-1:0]    iwv_rom_q,
  output logic [DATA_W-1:0]    owv_data,
  output logic                 ows_valid,
  input  logic                 iws_ready,
  output logic                 ows_busy,
  output logic                 ows_done,
  output logic [ChecksumW-1:0] owv_checksum
);

  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  LatMask = 4'((32'd1 << ROM_LAT) - 32'd1);
  localparam logic [ADDR_W:0] CntOne = 1;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q, last_addr_q, issue_addr;
  logic [ADDR_W:0]   len_q, issued_q, delivered_q;
  logic [3:0]        pipe_q;
  logic              busy_q, done_q;
  logic              issue, transfer, fifo_empty, fifo_full;
  logic [CntW-1:0]   fifo_count;
  int unsigned       outstanding;

  // Credits cover both words still in the ROM pipe and words parked in the FIFO.
  assign outstanding  = 32'(count_flags(pipe_q)) + 32'(fifo_count);
  assign issue        = (state_q == StRun) && (issued_q < len_q) &&
                        (outstanding < FIFO_DEPTH) && !fifo_full;
  assign issue_addr   = base_q + issued_q[ADDR_W-1:0];
  assign owv_rom_addr = issue ? issue_addr : last_addr_q;
  assign transfer     = ows_valid && iws_ready;
  assign ows_valid    = !fifo_empty;
  assign ows_busy     = busy_q;
  assign ows_done     = done_q;

  rom_reader_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (iws_clk),
    .rst     (iws_rst),
    .wr_en   (pipe_q[ROM_LAT-1]),
    .wr_data (iwv_rom_q),
    .rd_en   (transfer),
    .head    (owv_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge iws_clk) begin
    if (iws_rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      last_addr_q <= '0;
      pipe_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pipe_q <= {pipe_q[2:0], issue} & LatMask;
      done_q <= 1'b0;
      if (issue) begin
        last_addr_q <= issue_addr;
        issued_q    <= issued_q + CntOne;
      end
      if (transfer) delivered_q <= delivered_q + CntOne;
      unique case (state_q)
        StIdle: begin
          if (iws_start) begin
            if (iwv_len != '0) begin
              base_q      <= iwv_base_addr;
              len_q       <= iwv_len;
              issued_q    <= '0;
              delivered_q <= '0;
              busy_q      <= 1'b1;
              state_q     <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (issue && (issued_q + CntOne == len_q)) state_q <= StDrain;
        end
        StDrain: begin
          if (pipe_q == '0 && fifo_empty && delivered_q == len_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [ChecksumW-1:0] checksum_q;

  always_ff @(posedge iws_clk) begin
    if (iws_rst) begin
      checksum_q <= '0;
    end else if (state_q == StIdle && iws_start) begin
      checksum_q <= '0;
    end else if (transfer) begin
      checksum_q <= checksum_q + ChecksumW'(owv_data);
    end
  end

  assign owv_checksum = checksum_q;
`else
  assign owv_checksum = '0;
`endif

endmodule
